// File: rtl/phys_free_list_pkg.sv
// Shared sizing and tag type for the physical register free list.
package phys_free_list_pkg;
    localparam int SIZE_PHYSICAL_TABLE = 64;
    localparam int SIZE_RMT            = 32;
    localparam int PHY_INDEX           = 6;
    localparam int DISPATCH_WIDTH      = 4;
    localparam int COMMIT_WIDTH        = 4;
    localparam int FL_DEPTH            = SIZE_PHYSICAL_TABLE - SIZE_RMT;
    localparam int FL_PTR_W            = $clog2(FL_DEPTH);

    typedef logic [PHY_INDEX-1:0] phys_tag_t;
    typedef logic [FL_PTR_W-1:0]  fl_ptr_t;
endpackage

// File: rtl/fl_compact_idx.sv
// Mask to per-slot prefix-count offsets: slot i gets the number of set bits below it.
// Purely combinational; total is the popcount of the whole mask.
module fl_compact_idx #(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0]        mask,
    output logic [N-1:0][W-1:0] offs,
    output logic [W-1:0]        total
);
    logic [W-1:0] acc;

    always_comb begin
        acc  = '0;
        offs = '0;
        for (int i = 0; i < N; i++) begin
            offs[i] = acc;
            acc     = acc + {{(W-1){1'b0}}, mask[i]};
        end
        total = acc;
    end
endmodule

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical tags: all-or-nothing allocation of up to 4 tags per
// cycle (zero latency, presented from head) and compacted reclaim of up to 4 tags per cycle.
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DISPATCH_WIDTH-1:0] alloc_req_i,
    input  logic                      rename_ready_i,
    output logic [PHY_INDEX-1:0]      free_tag0_o,
    output logic [PHY_INDEX-1:0]      free_tag1_o,
    output logic [PHY_INDEX-1:0]      free_tag2_o,
    output logic [PHY_INDEX-1:0]      free_tag3_o,
    output logic [DISPATCH_WIDTH-1:0] free_tag_valid_o,
    output logic                      fl_stall_o,
    input  logic [COMMIT_WIDTH-1:0]   commit_free_i,
    input  logic [PHY_INDEX-1:0]      commit_tag0_i,
    input  logic [PHY_INDEX-1:0]      commit_tag1_i,
    input  logic [PHY_INDEX-1:0]      commit_tag2_i,
    input  logic [PHY_INDEX-1:0]      commit_tag3_i,
    output logic [PHY_INDEX:0]        free_count_o,
    output logic                      fl_overflow_o
);
    localparam int AW = $clog2(DISPATCH_WIDTH + 1);
    localparam int CMW = $clog2(COMMIT_WIDTH + 1);
    localparam int CW = PHY_INDEX + 1;

    phys_tag_t fl_mem [FL_DEPTH];
    fl_ptr_t   head_ptr;
    fl_ptr_t   tail_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic [DISPATCH_WIDTH-1:0][AW-1:0] rd_offs;
    logic [AW-1:0]                     need;
    logic [COMMIT_WIDTH-1:0][CMW-1:0]  wr_offs;
    logic [CMW-1:0]                    npush;

    fl_compact_idx #(.N(DISPATCH_WIDTH), .W(AW)) u_alloc_idx (
        .mask  (alloc_req_i),
        .offs  (rd_offs),
        .total (need)
    );

    fl_compact_idx #(.N(COMMIT_WIDTH), .W(CMW)) u_commit_idx (
        .mask  (commit_free_i),
        .offs  (wr_offs),
        .total (npush)
    );

    phys_tag_t       commit_tag [COMMIT_WIDTH];
    phys_tag_t       free_tag   [DISPATCH_WIDTH];
    logic            grant;
    logic [CW-1:0]   pop_n;
    logic [CW:0]     sum_next;
    logic            push_ovf;
    logic [CW-1:0]   count_next;

    assign commit_tag[0] = commit_tag0_i;
    assign commit_tag[1] = commit_tag1_i;
    assign commit_tag[2] = commit_tag2_i;
    assign commit_tag[3] = commit_tag3_i;

    // Stall uses registered count only; same-cycle reclaims are not visible yet.
    assign fl_stall_o = rename_ready_i && (CW'(need) > count);
    assign grant      = rename_ready_i && !fl_stall_o && (need != '0);

    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            free_tag[i] = '0;
            if (grant && alloc_req_i[i])
                free_tag[i] = fl_mem[fl_ptr_t'(head_ptr + fl_ptr_t'(rd_offs[i]))];
        end
    end

    assign free_tag0_o      = free_tag[0];
    assign free_tag1_o      = free_tag[1];
    assign free_tag2_o      = free_tag[2];
    assign free_tag3_o      = free_tag[3];
    assign free_tag_valid_o = grant ? alloc_req_i : '0;

    // A push that would overfill the list is dropped whole; the pop still happens.
    assign pop_n      = grant ? CW'(need) : '0;
    assign sum_next   = {1'b0, count} - {1'b0, pop_n} + (CW+1)'(npush);
    assign push_ovf   = sum_next > (CW+1)'(FL_DEPTH);
    assign count_next = push_ovf ? (count - pop_n) : sum_next[CW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < FL_DEPTH; k++)
                fl_mem[k] <= phys_tag_t'(SIZE_RMT + k);
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= CW'(FL_DEPTH);
            overflow <= 1'b0;
        end else begin
            if (grant)
                head_ptr <= fl_ptr_t'(head_ptr + fl_ptr_t'(need));
            if (push_ovf) begin
                overflow <= 1'b1;
            end else begin
                for (int i = 0; i < COMMIT_WIDTH; i++)
                    if (commit_free_i[i])
                        fl_mem[fl_ptr_t'(tail_ptr + fl_ptr_t'(wr_offs[i]))] <= commit_tag[i];
                tail_ptr <= fl_ptr_t'(tail_ptr + fl_ptr_t'(npush));
            end
            count <= count_next;
        end
    end

    assign free_count_o  = count;
    assign fl_overflow_o = overflow;
endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular FIFO of free physical register tags. It sits directly upstream of the rename map table.
- Each cycle it supplies up to DISPATCH_WIDTH fresh destination tags to the rename stage; those tags become the write data of the map-table write ports.
- It reclaims up to COMMIT_WIDTH tags per cycle from retire (previous mappings of committed destinations).
- Allocation is all-or-nothing per rename group; if the list cannot cover the group, rename stalls.

Parameters:
- SIZE_PHYSICAL_TABLE, 64, total physical registers.
- SIZE_RMT, 32, architectural registers. Tags 0..SIZE_RMT-1 are mapped at reset and are not free.
- PHY_INDEX, 6, tag width, log2(SIZE_PHYSICAL_TABLE).
- DISPATCH_WIDTH, 4, allocation ports.
- COMMIT_WIDTH, 4, reclaim ports.
- FL_DEPTH, SIZE_PHYSICAL_TABLE-SIZE_RMT, FIFO capacity (32).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- alloc_req_i  in  DISPATCH_WIDTH  per-slot "needs destination tag" mask for the current rename group.
- rename_ready_i  in  1  rename group valid and not stalled downstream.
- free_tag0_o..free_tag3_o  out  PHY_INDEX each  tags handed to requesting slots, in slot order.
- free_tag_valid_o  out  DISPATCH_WIDTH  per-slot tag valid (= alloc_req_i when the group is granted).
- fl_stall_o  out  1  insufficient free tags for the group.
- commit_free_i  in  COMMIT_WIDTH  per-slot reclaim valid.
- commit_tag0_i..commit_tag3_i  in  PHY_INDEX each  tags to return.
- free_count_o  out  PHY_INDEX+1  registered occupancy.
- fl_overflow_o  out  1  sticky error: push beyond FL_DEPTH.

Behaviour:
- Storage: FL_DEPTH x PHY_INDEX regfile; head_ptr and tail_ptr are log2(FL_DEPTH) bits; count is a separate register.
- Reset (reset==0 at clk edge):
  - entry k <= SIZE_RMT+k;
  - head_ptr <= 0; tail_ptr <= 0 (full, wrapped);
  - count <= FL_DEPTH; fl_overflow_o <= 0.
  - Reset wins over any concurrent request.
- need = popcount(alloc_req_i), range 0..DISPATCH_WIDTH.
- fl_stall_o (combinational) = rename_ready_i && (need > count). Uses registered count; same-cycle pushes do not count.
- Grant = rename_ready_i && !fl_stall_o && need>0.
- Tag outputs, combinational from head:
  - the j-th set bit of alloc_req_i (slot order) receives entry[head_ptr+j mod FL_DEPTH];
  - unrequested slots drive 0 with valid 0;
  - during stall all valid bits are 0.
- On grant: head_ptr += need (mod FL_DEPTH) at the edge. Tags are consumed in the same cycle they are presented, so latency is 0.
- Push:
  - valid commit slots are compacted in slot order and written at tail_ptr, tail_ptr+1, ...;
  - tail_ptr += popcount(commit_free_i).
- count_next = count - (grant ? need : 0) + npush. Push and pop in the same cycle are both applied.
- Simultaneous push/pop never collide: pop indices lie in [head, head+count); push indices lie at or after head+count.
- Overflow: if count_next would exceed FL_DEPTH:
  - fl_overflow_o <= 1 (sticky until reset);
  - the offending push is dropped entirely;
  - pop is still honoured.
- Empty list (count==0): any need>0 stalls; need==0 never stalls.
- Pointer wrap: all index arithmetic is modulo FL_DEPTH. FL_DEPTH is required to be a power of 2.
- Reset mid-stall: the next cycle shows a full list and fl_stall_o=0 for need<=DISPATCH_WIDTH.

Decomposition:
- Shared package holds:
  - SIZE_PHYSICAL_TABLE, SIZE_RMT, PHY_INDEX, DISPATCH_WIDTH, COMMIT_WIDTH;
  - typedef phys_tag_t [PHY_INDEX-1:0].
- One sub-module: fl_compact_idx. It is a generic N-bit mask to per-slot prefix-count offsets, instantiated once for alloc (read offsets) and once for commit (write offsets).

Test Plan:
- Reset then alloc_req_i=4'b1111, ready=1 -> tags 32,33,34,35, valid 1111; next cycle free_count_o=28.
- alloc_req_i=4'b1010 from fresh reset -> slot1 gets 32, slot3 gets 33, slots 0/2 valid 0; count=30.
- Drain to count=2, request 4'b0111 -> fl_stall_o=1, no valids, head and count unchanged. The same request with commit_free_i=4'b0011 (tags 5,9) stalls this cycle and is granted the next cycle with tags [old two, 5].
- Wrap: 8 cycles of 4-alloc then 8 cycles of 4-push of tags 0..31 -> next allocs return 0,1,2,3 with head wrapped to 0; count returns to 32.
- At count=32, push 1 tag -> fl_overflow_o=1 and stays set; count stays 32; the contents at tail are unchanged.
- Simultaneous 4-pop and 4-push at count=4 -> all four old tags granted, count=4, new tags appear in the next allocation in commit slot order.
